vector_conversion_issue_controller: RTL

VECTOR_CONVERSION_ISSUE_CONTROLLER -- requirements
Module: vector_conversion_issue_controller

---
 rtl/vector_conversion_issue_controller.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vector_conversion_issue_controller.sv
// Two-requester round-robin issue into a fixed-latency conversion unit. Issued operations
// are tracked through a valid/tag/src shift register and land in a credit-protected in-order FIFO.
module vector_conversion_issue_controller #(
  parameter int VLEN    = 128,
  parameter int EV_W    = 64,
  parameter int TAG_W   = 4,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [EV_W-1:0]  req0_execution_vector,
  input  logic [VLEN-1:0]  req0_vs2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [EV_W-1:0]  req1_execution_vector,
  input  logic [VLEN-1:0]  req1_vs2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [EV_W-1:0]  cvt_execution_vector,
  output logic [VLEN-1:0]  cvt_vs2,
  input  logic [VLEN-1:0]  cvt_vd,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [VLEN-1:0]  res_vd,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_src,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic               last_grant;
  logic [LATENCY-1:0] vld_p;
  logic [TAG_W-1:0]   tag_p [LATENCY];
  logic               src_p [LATENCY];
  logic [CNT_W-1:0]   inflight_count;
  logic [CNT_W-1:0]   fifo_count;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [VLEN-1:0]    mem_vd  [DEPTH];
  logic [TAG_W-1:0]   mem_tag [DEPTH];
  logic               mem_src [DEPTH];

  logic credit_ok;
  logic grant0;
  logic grant1;
  logic issue0;
  logic issue1;
  logic issue;
  logic push;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    credit_ok = (inflight_count + fifo_count) < DEPTH_C;
    // A requester's grant looks only at the other requester's valid.
    grant0 = !req1_valid || last_grant;
    grant1 = !req0_valid || !last_grant;
    req0_ready = !reset && grant0 && credit_ok;
    req1_ready = !reset && grant1 && credit_ok;
    issue0 = req0_valid && req0_ready;
    issue1 = req1_valid && req1_ready;
    issue  = issue0 || issue1;
    push   = vld_p[LATENCY-1];
    pop    = res_valid && res_ready;
    cvt_execution_vector = '0;
    cvt_vs2              = '0;
    if (issue0) begin
      cvt_execution_vector = req0_execution_vector;
      cvt_vs2              = req0_vs2;
    end else if (issue1) begin
      cvt_execution_vector = req1_execution_vector;
      cvt_vs2              = req1_vs2;
    end
  end

  assign res_valid = (fifo_count != '0);
  assign res_vd    = res_valid ? mem_vd[rd_ptr]  : '0;
  assign res_tag   = res_valid ? mem_tag[rd_ptr] : '0;
  assign res_src   = res_valid ? mem_src[rd_ptr] : 1'b0;
  assign busy      = (|vld_p) || res_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant     <= 1'b1;
      vld_p          <= '0;
      inflight_count <= '0;
      fifo_count     <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
    end else begin
      // Stage boundary: issue -> p0 ... p[LATENCY-1] -> FIFO push
      vld_p[0] <= issue;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
      if (issue0) last_grant <= 1'b0;
      else if (issue1) last_grant <= 1'b1;
      if (issue && !push) inflight_count <= inflight_count + CNT_ONE;
      else if (!issue && push) inflight_count <= inflight_count - CNT_ONE;
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop) fifo_count <= fifo_count + CNT_ONE;
      else if (!push && pop) fifo_count <= fifo_count - CNT_ONE;
    end
  end

  always_ff @(posedge clock) begin
    tag_p[0] <= issue1 ? req1_tag : req0_tag;
    src_p[0] <= issue1;
    for (int i = 1; i < LATENCY; i++) begin
      tag_p[i] <= tag_p[i-1];
      src_p[i] <= src_p[i-1];
    end
    if (push) begin
      mem_vd[wr_ptr]  <= cvt_vd;
      mem_tag[wr_ptr] <= tag_p[LATENCY-1];
      mem_src[wr_ptr] <= src_p[LATENCY-1];
    end
  end

endmodule
